// File: rtl/cpu_ctrl_fsm_if.sv
// rtl/cpu_ctrl_fsm_if.sv - control/status bundle between cpu_ctrl_fsm (master) and the datapath (slave)
interface cpu_ctrl_fsm_if;
    logic [7:0] instruction;
    logic       zero_flag;
    logic       mem_ready;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       reg_we;
    logic       wb_sel;
    logic       addr_sel;
    logic [2:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;

    modport master (
        input  instruction, zero_flag, mem_ready,
        output ir_load, pc_inc, pc_load, reg_we, wb_sel, addr_sel, alu_op, mem_rd, mem_wr
    );

    modport slave (
        output instruction, zero_flag, mem_ready,
        input  ir_load, pc_inc, pc_load, reg_we, wb_sel, addr_sel, alu_op, mem_rd, mem_wr
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the 8-bit RISC datapath
// Optional feature macro: CTRL_BRANCH_EN (JMP/BEQ support; otherwise opcodes A/B are illegal)
module cpu_ctrl_fsm #(
    parameter int FETCH_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    cpu_ctrl_fsm_if.master    dp,
    output logic              illegal_op,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
`ifdef CTRL_BRANCH_EN
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
`endif
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b101;

    if (FETCH_TIMEOUT != 0) begin : g_timeout_unsupported
        $error("cpu_ctrl_fsm: FETCH_TIMEOUT must be 0");
    end

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic       unused_operands;

    assign opcode          = dp.instruction[7:4];
    assign unused_operands = ^{dp.instruction[3:0], dp.zero_flag};
    assign state           = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        dp.ir_load  = 1'b0;
        dp.pc_inc   = 1'b0;
        dp.pc_load  = 1'b0;
        dp.reg_we   = 1'b0;
        dp.wb_sel   = 1'b0;
        dp.addr_sel = 1'b0;
        dp.alu_op   = ALU_ADD;
        dp.mem_rd   = 1'b0;
        dp.mem_wr   = 1'b0;
        illegal_op  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    dp.mem_rd = 1'b1;
                    if (dp.mem_ready) begin
                        dp.ir_load = 1'b1;
                        dp.pc_inc  = 1'b1;
                        state_d    = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:                                         state_d = S_FETCH;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV:  state_d = S_EXEC;
`ifdef CTRL_BRANCH_EN
                    OP_JMP, OP_BEQ:                                 state_d = S_EXEC;
`endif
                    OP_LD, OP_ST:                                   state_d = S_MEM;
                    OP_HLT:                                         state_d = S_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_ADD: begin dp.alu_op = ALU_ADD;  dp.reg_we = 1'b1; end
                    OP_SUB: begin dp.alu_op = ALU_SUB;  dp.reg_we = 1'b1; end
                    OP_AND: begin dp.alu_op = ALU_AND;  dp.reg_we = 1'b1; end
                    OP_OR:  begin dp.alu_op = ALU_OR;   dp.reg_we = 1'b1; end
                    OP_XOR: begin dp.alu_op = ALU_XOR;  dp.reg_we = 1'b1; end
                    OP_MOV: begin dp.alu_op = ALU_PASS; dp.reg_we = 1'b1; end
`ifdef CTRL_BRANCH_EN
                    OP_JMP: dp.pc_load = 1'b1;
                    OP_BEQ: dp.pc_load = dp.zero_flag;
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                // Strobe stays up until the memory acknowledges; a slow memory just stretches MEM.
                dp.addr_sel = 1'b1;
                if (opcode == OP_LD) dp.mem_rd = 1'b1;
                else                 dp.mem_wr = 1'b1;
                if (dp.mem_ready) state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                dp.reg_we = 1'b1;
                dp.wb_sel = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Reset kills strobes within the same timestep, before the state flop has a clock.
        if (rst) begin
            state_d     = S_FETCH;
            dp.ir_load  = 1'b0;
            dp.pc_inc   = 1'b0;
            dp.pc_load  = 1'b0;
            dp.reg_we   = 1'b0;
            dp.wb_sel   = 1'b0;
            dp.addr_sel = 1'b0;
            dp.alu_op   = ALU_ADD;
            dp.mem_rd   = 1'b0;
            dp.mem_wr   = 1'b0;
            illegal_op  = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       illegal_op;
    logic       halted;
    logic [2:0] state;
    int         total = 0;
    int         bad   = 0;

    cpu_ctrl_fsm_if dp_if ();

    cpu_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dp         (dp_if),
        .illegal_op (illegal_op),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {ir_load, pc_inc, pc_load, reg_we, wb_sel, addr_sel, alu_op[2:0], mem_rd, mem_wr, illegal_op, halted, state[2:0]}
    logic [15:0] outs;
    assign outs = {dp_if.ir_load, dp_if.pc_inc, dp_if.pc_load, dp_if.reg_we, dp_if.wb_sel,
                   dp_if.addr_sel, dp_if.alu_op, dp_if.mem_rd, dp_if.mem_wr, illegal_op,
                   halted, state};

    localparam logic [15:0] V_RESET     = 16'h0000;
    localparam logic [15:0] V_FETCH_OK  = 16'hC040;
    localparam logic [15:0] V_FETCH_IDL = 16'h0000;
    localparam logic [15:0] V_DECODE    = 16'h0001;
    localparam logic [15:0] V_DEC_ILL   = 16'h0011;
    localparam logic [15:0] V_MEM_LD    = 16'h0443;
    localparam logic [15:0] V_MEM_ST    = 16'h0423;
    localparam logic [15:0] V_WB        = 16'h1804;
    localparam logic [15:0] V_HALT      = 16'h000D;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] alu_ops [6]  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};
    logic [15:0] alu_exp [6] = '{16'h1002, 16'h1082, 16'h1102, 16'h1182, 16'h1202, 16'h1282};

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b1;
        dp_if.mem_ready   = 1'b1;
        dp_if.zero_flag   = 1'b0;
        dp_if.instruction = 8'h16;

        tick; check("reset_c1", outs, V_RESET);
        tick; check("reset_c2", outs, V_RESET);
        rst = 1'b0;
        #1 check("first_fetch", outs, V_FETCH_OK);

        // ADD r1,r2
        tick; check("add_decode", outs, V_DECODE);
        tick; check("add_exec", outs, 16'h1002);
        tick; check("add_back_fetch", outs, V_FETCH_OK);

        for (int i = 0; i < 6; i++) begin
            dp_if.instruction = {alu_ops[i], 4'h6};
            tick; check("alu_decode", outs, V_DECODE);
            tick; check("alu_exec", outs, alu_exp[i]);
            tick; check("alu_fetch", outs, V_FETCH_OK);
        end

        // run low stalls in FETCH even with ready
        run = 1'b0;
        #1 check("run_low", outs, V_FETCH_IDL);
        tick; check("run_low_hold", outs, V_FETCH_IDL);
        run = 1'b1;
        dp_if.mem_ready = 1'b0;
        #1 check("fetch_wait", outs, 16'h0040);
        tick; check("fetch_wait_hold", outs, 16'h0040);
        dp_if.mem_ready = 1'b1;

        // LD r3,[r1] with two wait states
        dp_if.instruction = 8'h8D;
        #1 check("ld_fetch", outs, V_FETCH_OK);
        tick; check("ld_decode", outs, V_DECODE);
        dp_if.mem_ready = 1'b0;
        tick; check("ld_mem_w1", outs, V_MEM_LD);
        tick; check("ld_mem_w2", outs, V_MEM_LD);
        tick;
        dp_if.mem_ready = 1'b1;
        #1 check("ld_mem_rdy", outs, V_MEM_LD);
        tick; check("ld_wb", outs, V_WB);
        tick; check("ld_fetch_next", outs, V_FETCH_OK);

        // ST r1,[r0]
        dp_if.instruction = 8'h94;
        tick; check("st_decode", outs, V_DECODE);
        tick; check("st_mem", outs, V_MEM_ST);
        tick; check("st_fetch_next", outs, V_FETCH_OK);

        // NOP
        dp_if.instruction = 8'h00;
        tick; check("nop_decode", outs, V_DECODE);
        tick; check("nop_fetch", outs, V_FETCH_OK);

        // BEQ r2 with zero_flag 0 then 1, then JMP
`ifdef CTRL_BRANCH_EN
        dp_if.instruction = 8'hB2;
        tick; check("beq0_decode", outs, V_DECODE);
        tick; check("beq0_exec", outs, 16'h0002);
        tick; check("beq0_fetch", outs, V_FETCH_OK);
        dp_if.zero_flag = 1'b1;
        tick; check("beq1_decode", outs, V_DECODE);
        tick; check("beq1_exec", outs, 16'h2002);
        tick; check("beq1_fetch", outs, V_FETCH_OK);
        dp_if.zero_flag = 1'b0;
        dp_if.instruction = 8'hA1;
        tick; check("jmp_decode", outs, V_DECODE);
        tick; check("jmp_exec", outs, 16'h2002);
        tick; check("jmp_fetch", outs, V_FETCH_OK);
`else
        dp_if.instruction = 8'hB2;
        dp_if.zero_flag = 1'b1;
        tick; check("beq_illegal", outs, V_DEC_ILL);
        tick; check("beq_ill_fetch", outs, V_FETCH_OK);
        dp_if.zero_flag = 1'b0;
        dp_if.instruction = 8'hA1;
        tick; check("jmp_illegal", outs, V_DEC_ILL);
        tick; check("jmp_ill_fetch", outs, V_FETCH_OK);
`endif

        // Illegal opcodes C and 6
        dp_if.instruction = 8'hC0;
        tick; check("illc_decode", outs, V_DEC_ILL);
        tick; check("illc_fetch", outs, V_FETCH_OK);
        dp_if.instruction = 8'h60;
        tick; check("ill6_decode", outs, V_DEC_ILL);
        tick; check("ill6_fetch", outs, V_FETCH_OK);

        // HLT holds through run/ready toggling
        dp_if.instruction = 8'hF0;
        tick; check("hlt_decode", outs, V_DECODE);
        for (int i = 0; i < 10; i++) begin
            tick; check("halt_hold", outs, V_HALT);
            run = i[0];
            dp_if.mem_ready = ~i[0];
        end
        run = 1'b1;
        dp_if.mem_ready = 1'b1;
        rst = 1'b1;
        #1 check("halt_reset", outs, V_RESET);
        tick;
        rst = 1'b0;
        #1 check("halt_restart", outs, V_FETCH_OK);

        // Reset while ST waits in MEM
        dp_if.instruction = 8'h94;
        tick; check("st2_decode", outs, V_DECODE);
        dp_if.mem_ready = 1'b0;
        tick; check("st2_mem", outs, V_MEM_ST);
        rst = 1'b1;
        #1 check("st2_async_reset", outs, V_RESET);
        tick;
        rst = 1'b0;
        dp_if.mem_ready = 1'b1;
        #1 check("st2_restart", outs, V_FETCH_OK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
